// File: rtl/gray_pkg.sv
// gray_pkg: mode encoding and XOR-chain segment sizing shared by
// the pipelined Gray/binary codec.
package gray_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  function automatic int seg_width(input int n, input int s);
    return (n + s - 1) / s;
  endfunction

endpackage

// File: rtl/gray_seg_stage.sv
// gray_seg_stage: one codec pipeline stage with its slice of the
// Gray-to-binary XOR chain. GRAY_STEPCHK_EN adds an err bit per beat.
module gray_seg_stage
  import gray_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         up_valid,
  input  logic         up_mode,
  input  logic         up_carry,
  input  logic [N-1:0] up_data,
`ifdef GRAY_STEPCHK_EN
  input  logic         up_err,
  output logic         err,
`endif
  output logic         valid,
  output logic         mode,
  output logic         carry,
  output logic [N-1:0] data
);

  localparam int SEG = seg_width(N, STAGES);
  localparam int HI  = N - 1 - IDX * SEG;
  localparam int LO  = (IDX == STAGES - 1) ? 0 :
                       (N - (IDX + 1) * SEG < 0) ? 0 :
                       N - (IDX + 1) * SEG;

  logic [N-1:0] nxt_data;
  logic         nxt_carry;

  // bits above HI are already binary, bits below LO still Gray
  always_comb begin
    nxt_data  = up_data;
    nxt_carry = up_carry;
    if (up_mode == MODE_G2B) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i <= HI && i >= LO) begin
          nxt_carry   = nxt_carry ^ up_data[i];
          nxt_data[i] = nxt_carry;
        end
      end
    end else if (IDX == 0) begin
      nxt_data = up_data ^ (up_data >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      mode  <= MODE_B2G;
      carry <= 1'b0;
      data  <= '0;
`ifdef GRAY_STEPCHK_EN
      err   <= 1'b0;
`endif
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        mode  <= up_mode;
        carry <= nxt_carry;
        data  <= nxt_data;
`ifdef GRAY_STEPCHK_EN
        err   <= up_err;
`endif
      end
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: valid/ready pipelined binary<->Gray converter.
// Define GRAY_STEPCHK_EN to add the Gray step checker and out_err.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
`ifdef GRAY_STEPCHK_EN
  output logic         out_err,
`endif
  output logic [N-1:0] out_data
);

  logic         s_valid [STAGES];
  logic         s_mode  [STAGES];
  logic         s_carry [STAGES];
  logic [N-1:0] s_data  [STAGES];
  logic [STAGES-1:0] adv;
  logic         in_fire;
  logic         unused_carry;

  // a stage moves when anything downstream has room
  always_comb begin
    logic a;
    a   = out_ready;
    adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      a      = !s_valid[k] || a;
      adv[k] = a;
    end
  end

  assign in_ready = rst_n && en && adv[0];
  assign in_fire  = in_valid && in_ready;

`ifdef GRAY_STEPCHK_EN
  logic [N-1:0] hist_q;
  logic         hist_v_q;
  logic         in_err;
  logic         s_err [STAGES];

  assign in_err = (in_mode == MODE_G2B) && hist_v_q &&
                  ($countones(in_data ^ hist_q) != 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q   <= '0;
      hist_v_q <= 1'b0;
    end else if (in_fire) begin
      hist_v_q <= (in_mode == MODE_G2B);
      if (in_mode == MODE_G2B) hist_q <= in_data;
    end
  end
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         up_v;
    logic         up_m;
    logic         up_c;
    logic [N-1:0] up_d;
`ifdef GRAY_STEPCHK_EN
    logic         up_e;
`endif
    if (k == 0) begin : g_head
      assign up_v = in_fire;
      assign up_m = in_mode;
      assign up_c = 1'b0;
      assign up_d = in_data;
`ifdef GRAY_STEPCHK_EN
      assign up_e = in_err;
`endif
    end else begin : g_body
      assign up_v = s_valid[k-1];
      assign up_m = s_mode[k-1];
      assign up_c = s_carry[k-1];
      assign up_d = s_data[k-1];
`ifdef GRAY_STEPCHK_EN
      assign up_e = s_err[k-1];
`endif
    end

    gray_seg_stage #(
      .N      (N),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (adv[k]),
      .up_valid (up_v),
      .up_mode  (up_m),
      .up_carry (up_c),
      .up_data  (up_d),
`ifdef GRAY_STEPCHK_EN
      .up_err   (up_e),
      .err      (s_err[k]),
`endif
      .valid    (s_valid[k]),
      .mode     (s_mode[k]),
      .carry    (s_carry[k]),
      .data     (s_data[k])
    );
  end

  assign unused_carry = s_carry[STAGES-1];

  assign out_valid = s_valid[STAGES-1];
  assign out_mode  = out_valid & s_mode[STAGES-1];
  assign out_data  = out_valid ? s_data[STAGES-1] : '0;
`ifdef GRAY_STEPCHK_EN
  assign out_err   = out_valid & s_err[STAGES-1];
`endif

endmodule

// File: doc/gray_codec_pipe.md
GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 The block SHALL have parameter N, default 8, which sets the data width in bits (N >= 2).
REQ-002 The block SHALL have parameter STAGES, default 2, which sets the pipeline depth (1 <= STAGES <= N).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: intake enable.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input beat is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the input beat this cycle.
REQ-008 The block SHALL have port in_mode, input, 1 bit: 1 = Gray-to-binary, 0 = binary-to-Gray.
REQ-009 The block SHALL have port in_data, input, N bits: the input word.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the output beat is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.
REQ-012 The block SHALL have port out_mode, output, 1 bit: the in_mode that travelled with the beat.
REQ-013 The block SHALL have port out_data, output, N bits: the converted word.
REQ-014 The block SHALL have port out_err, output, 1 bit, present only under GRAY_STEPCHK_EN: the beat is a Gray step violation.

Function
REQ-015 A beat SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-016 in_ready SHALL equal en && (stage 1 empty || stage 1 advancing this cycle).
- Stage k advances when stage k+1 is empty or advancing.
- The last stage advances when it is empty or out_ready=1.
REQ-017 With no backpressure, latency SHALL be exactly STAGES cycles from the input handshake to out_valid=1, at a throughput of one beat per cycle.
REQ-018 Bubbles SHALL collapse: an empty stage always accepts from the stage before it, regardless of out_ready.
REQ-019 A stalled beat SHALL keep out_data, out_mode, and out_err stable until it is accepted.
REQ-020 out_data and out_err SHALL be 0 whenever out_valid=0.
REQ-021 Mode 0 SHALL produce out = x ^ (x >> 1).
- Computed entirely in stage 1.
- Later stages only pass the result through.
REQ-022 Mode 1 SHALL produce b[N-1] = g[N-1] and b[i] = b[i+1] ^ g[i].
- The XOR chain is split MSB-first into STAGES segments of ceil(N/STAGES) bits.
- Any remainder goes in the last segment; with N=8 and STAGES=3 the segments are 3, 3, 2.
- Stage k resolves its segment using the carried bit from stage k-1.
REQ-023 Beats of both modes SHALL interleave freely; each beat is converted per its own mode, with no flush between beats.
REQ-024 en=0 SHALL block intake only; beats already in flight continue to drain normally.
REQ-025 A simultaneous input and output handshake on a full pipeline SHALL lose or duplicate no beat.

Reset
REQ-026 With rst_n=0 at a clock edge, the block SHALL:
- clear every stage valid bit;
- clear the step-check history;
- drive out_valid=0, out_data=0, out_err=0, and out_mode=0 on the following cycle.
REQ-027 A reset during operation SHALL discard all in-flight beats, with no partial output afterwards.
REQ-028 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-029 With macro GRAY_STEPCHK_EN defined, the block SHALL check Gray steps.
- It keeps the last accepted mode-1 input word plus a history-valid flag.
- A mode-1 beat whose input differs from that word in a number of bits other than exactly 1 carries out_err=1; identical words are also errors.
- The first mode-1 beat after reset is not checked.
- A mode-0 beat clears the history-valid flag.
REQ-030 Without GRAY_STEPCHK_EN, the out_err port and its history registers SHALL be absent; all other behaviour is identical.

Structure
REQ-031 The shared package gray_pkg SHALL hold:
- the mode encoding constants MODE_B2G=0 and MODE_G2B=1;
- a function computing the segment width ceil(N/STAGES).
REQ-032 A single sub-module gray_seg_stage SHALL implement one pipeline stage: valid/data/mode/carry registers plus the XOR segment; the top level instantiates it STAGES times with a generate loop.

Verification (N=8, STAGES=2 unless stated)
REQ-033 Mode 0, in 0x05 then 0x80 back-to-back with out_ready=1 -> out 0x07 then 0xC0, out_valid high 2 and 3 cycles after the first input.
REQ-034 Mode 1, in 0xC0, 0x07, 0xFF; STAGES=3 -> out 0x80, 0x05, 0xAA, each 3 cycles after its input.
REQ-035 Fill the pipeline with out_ready=0 -> in_ready drops after 2 accepted beats and out_data holds; release out_ready -> beats appear in order, none lost.
REQ-036 Stream 4 beats, assert rst_n=0 for 1 cycle mid-stream -> out_valid=0 next cycle and no beat from before reset ever appears.
REQ-037 GRAY_STEPCHK_EN, mode 1, in 0x00, 0x01, 0x03, 0x00 -> out_err 0, 0, 0, 1; then one mode-0 beat, then mode-1 0x55 -> out_err 0.
